wb_uart_tx_slave: RTL and testbench
===================================

Name: wb_uart_tx_slave

Overview:
- Wishbone classic responder that accepts bytes from the picorv32 Wishbone initiator and serialises them out on a UART TX line as 8N1 frames.
- Contains a write FIFO, a programmable bit-period divisor and a status register.
- Sits on the SoC data bus alongside boot ROM and SRAM, and drives the board UART_TXD pin.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DIVISOR_RESET, 86, clocks per UART bit after reset (10 MHz / 115200).

Ports:
- clock  input  1  single system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- wb_adr_i  input  4  byte address; only [3:2] decoded.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte lane selects.
- wb_we_i  input  1  write enable.
- wb_stb_i  input  1  strobe.
- wb_cyc_i  input  1  cycle.
- wb_dat_o  output  32  read data, valid while wb_ack_o=1.
- wb_ack_o  output  1  single-cycle acknowledge.
- uart_tx  output  1  serial output; idles high.
- irq_o  output  1  high when the FIFO is empty and the serializer is idle.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - uart_tx=1, wb_ack_o=0, wb_dat_o=0, irq_o=1;
  - FIFO empty, overflow flag=0, divisor=DIVISOR_RESET, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately; uart_tx goes high without waiting for the clock.
- Request cycle: wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - Register side effects happen in the request cycle.
  - wb_ack_o is high the following cycle for exactly one cycle.
  - wb_dat_o is registered with the ack and is 0 when ack=0.
  - Minimum of 2 cycles per access; no wait states, no err/rty.
- Register map (wb_adr_i[3:2]):
  - 0 TXDATA: write with sel[0] pushes dat_i[7:0] into the FIFO; read returns 0.
  - 1 STATUS (read):
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - [15:8] FIFO level
    - other bits 0.
  - 1 STATUS (write): with sel[0] and dat_i[3]=1, clears overflow; other bits are ignored.
  - 2 DIVISOR: 16 bits in [15:0], written per byte lane sel[1:0].
    - Stored value <2 is clamped to 2 on write.
    - Read returns the clamped value.
  - 3: reads 0; writes are ignored and still acked.
- FIFO rules:
  - Full is evaluated before any same-cycle pop.
  - A push while full is dropped, sets overflow=1 and is still acked.
  - Push and pop in the same cycle (not full, not empty) leaves the level unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH; the level counter is one bit wider than the pointers.
- Serializer FSM states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop one byte, latch it and the current divisor D, then go to START. The pop and the transition happen in the same cycle.
  - START: uart_tx=0 for D clocks, then DATA.
  - DATA: 8 bits, LSB first, D clocks each; a bit counter 0..7 selects the bit; then STOP.
  - STOP: uart_tx=1 for D clocks, then IDLE.
  - With continuous data, the first cycle after STOP completes is the IDLE pop cycle, so back-to-back frames are 10*D+1 clocks apart; uart_tx stays high during that extra cycle.
  - A divisor written mid-frame takes effect at the next frame only.
- irq_o = empty & (FSM==IDLE), registered; it asserts the cycle after the last stop bit completes with an empty FIFO.

Test Plan:
- Reset release, then read STATUS and DIVISOR -> STATUS=0x00000004, DIVISOR=86, uart_tx=1, irq_o=1, each ack exactly one cycle after request.
- Write DIVISOR=4, TXDATA=0x55 -> uart_tx low 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks; busy reads 1 during the frame; irq_o drops while sending and returns after the stop bit.
- Divisor 4, three back-to-back writes 0xA5,0x01,0xFF -> three frames with start-bit falling edges exactly 41 clocks apart, correct LSB-first data, FIFO level read mid-stream decrements 2,1,0.
- Divisor 1000, write 17 bytes with FIFO_DEPTH=16 -> first byte popped, 16 buffered, all 17 acked, no overflow; an 18th write -> overflow=1, full=1; write STATUS 0x8 -> overflow=0.
- Write DIVISOR=1, and DIVISOR=0x1234 with sel=4'b0001 -> reads back 2, then 0x0034.
- Assert reset mid-DATA -> uart_tx=1 within the same cycle; after release STATUS=0x4 and the old FIFO contents are never transmitted.

Source files
------------

// File: rtl/wb_uart_tx_slave.sv
// Wishbone classic responder feeding an 8N1 UART transmitter through a byte FIFO.
// Registers: TXDATA (0x0), STATUS (0x4), DIVISOR (0x8), reserved (0xC).
module wb_uart_tx_slave #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [15:0] DIVISOR_RESET = 16'd86
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        uart_tx,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, dlat_q, dlat_d, div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d, irq_q, irq_d, ack_q, ack_d, ovf_q, ovf_d;
  logic [31:0]   dat_q, dat_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic        req, wr, full, empty, push_req, push, pop, last;
  logic [1:0]  addr;
  logic [15:0] div_new;
  logic [31:0] status, rdata;
  logic        unused_ok;

  assign unused_ok = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

  always_comb begin
    req      = wb_cyc_i & wb_stb_i & ~ack_q;
    wr       = req & wb_we_i;
    addr     = wb_adr_i[3:2];
    full     = (level_q == LW'(FIFO_DEPTH));
    empty    = (level_q == '0);
    push_req = wr & (addr == 2'd0) & wb_sel_i[0];
    push     = push_req & ~full;
    pop      = (state_q == IDLE) & ~empty;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A push that finds the FIFO full is dropped but still acknowledged.
    ovf_d = ovf_q;
    if (wr && addr == 2'd1 && wb_sel_i[0] && wb_dat_i[3]) ovf_d = 1'b0;
    if (push_req && full) ovf_d = 1'b1;

    div_new = div_q;
    if (wb_sel_i[0]) div_new[7:0]  = wb_dat_i[7:0];
    if (wb_sel_i[1]) div_new[15:8] = wb_dat_i[15:8];
    if (div_new < 16'd2) div_new = 16'd2;
    div_d = (wr && addr == 2'd2) ? div_new : div_q;

    status = {16'h0, 8'(level_q), 4'h0, ovf_q, empty, full, state_q != IDLE};
    unique case (addr)
      2'd1:    rdata = status;
      2'd2:    rdata = {16'h0, div_q};
      default: rdata = '0;
    endcase
    ack_d = req;
    dat_d = (req && !wb_we_i) ? rdata : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dlat_d  = dlat_q;
    last    = (cnt_q == dlat_q - 16'd1);
    unique case (state_q)
      IDLE: if (!empty) begin
        state_d = START;
        shreg_d = mem_q[rd_ptr_q];
        dlat_d  = div_q;
        cnt_d   = '0;
      end
      START: if (last) begin
        state_d = DATA;
        cnt_d   = '0;
        bit_d   = '0;
      end else cnt_d = cnt_q + 16'd1;
      DATA: if (last) begin
        cnt_d = '0;
        if (bit_q == 3'd7) state_d = STOP;
        else bit_d = bit_q + 3'd1;
      end else cnt_d = cnt_q + 16'd1;
      STOP: if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
    // Line level and irq come from next-state values so both outputs stay registered.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    irq_d = (level_d == '0) & (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      dlat_q   <= DIVISOR_RESET;
      div_q    <= DIVISOR_RESET;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      dlat_q   <= dlat_d;
      div_q    <= div_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wb_dat_i[7:0];
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign uart_tx  = tx_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_uart_tx_slave.sv
// Self-checking bench for wb_uart_tx_slave: register reads and UART frames are
// scored against queues of expected values filled as stimulus is driven.
module tb_wb_uart_tx_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, uart_tx, irq_o;

  wb_uart_tx_slave #(.FIFO_DEPTH(16), .DIVISOR_RESET(16'd86)) dut (
    .clock(clock), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .uart_tx(uart_tx), .irq_o(irq_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] rd_sb [$];
  logic [7:0]  tx_sb [$];
  int          fall_cyc [$];
  int          n_falls = 0, n_frames = 0, cur_div = 86;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples each bit mid-period using the divisor in force at the start edge.
  logic       m_act = 1'b0;
  int         m_cnt = 0, m_d = 2, m_k = 0;
  logic [7:0] m_byte = '0;
  always @(negedge clock) begin
    if (!reset) m_act = 1'b0;
    else if (!m_act) begin
      if (uart_tx == 1'b0) begin
        m_act = 1'b1; m_cnt = 0; m_d = cur_div; n_falls++;
        fall_cyc.push_back(cyc);
      end
    end else m_cnt++;
    if (reset && m_act && (m_cnt % m_d) == m_d / 2) begin
      m_k = m_cnt / m_d;
      if (m_k == 0) check("uart_start", uart_tx, 0);
      else if (m_k <= 8) m_byte[m_k-1] = uart_tx;
      else begin
        check("uart_stop", uart_tx, 1);
        check("uart_sb_avail", tx_sb.size() != 0, 1);
        if (tx_sb.size() != 0) check("uart_byte", m_byte, tx_sb.pop_front());
        n_frames++;
        m_act = 1'b0;
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(posedge clock); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    lat = -1; rd = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock); #1;
      if (wb_ack_o) begin lat = i; rd = wb_dat_o; break; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input string tag);
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, adr, dat, sel, rd, lat);
    check({tag, "_ack_lat"}, lat, 1);
  endtask

  task automatic wb_read(input logic [3:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] rd, e;
    int lat;
    rd_sb.push_back(exp);
    wb_xfer(1'b0, adr, '0, 4'hF, rd, lat);
    e = rd_sb.pop_front();
    check({tag, "_ack_lat"}, lat, 1);
    check(tag, rd, e);
  endtask

  task automatic send(input logic [7:0] b);
    tx_sb.push_back(b);
    wb_write(4'h0, {24'h0, b}, 4'b0001, "txdata");
  endtask

  task automatic wait_count(input int target, input int which, input string tag);
    int t = 0;
    while (((which == 0) ? n_falls : n_frames) < target && t < 5000) begin
      @(posedge clock); #1; t++;
    end
    check(tag, ((which == 0) ? n_falls : n_frames) >= target, 1);
  endtask

  logic [63:0] got_w, exp_w;
  logic [7:0]  b55;
  logic        found;
  int          base_f, base_fr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_irq", irq_o, 1);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Reset state via registers; ack lasts one cycle and data returns to 0.
    wb_read(4'h4, 32'h0000_0004, "status_rst");
    @(posedge clock); #1;
    check("ack_one_cycle", wb_ack_o, 0);
    check("dat_zero_idle", wb_dat_o, 0);
    wb_read(4'h8, 32'd86, "div_rst");
    check("idle_tx", uart_tx, 1);
    check("idle_irq", irq_o, 1);

    // Single 0x55 frame at divisor 4, checked cycle by cycle.
    wb_write(4'h8, 32'd4, 4'b0011, "div4");
    cur_div = 4;
    send(8'h55);
    fork
      begin
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(posedge clock); #1;
          if (uart_tx == 1'b0) begin found = 1'b1; break; end
        end
        check("frame55_start_seen", found, 1);
        got_w = '0;
        got_w[0] = uart_tx;
        for (int i = 1; i < 40; i++) begin
          @(posedge clock); #1;
          got_w[i] = uart_tx;
        end
        b55 = 8'h55;
        exp_w = '0;
        for (int i = 0; i < 40; i++)
          exp_w[i] = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : b55[(i / 4) - 1];
        check("frame55_wave", got_w, exp_w);
      end
      begin
        repeat (10) @(posedge clock);
        #1;
        check("irq_low_busy", irq_o, 0);
        wb_read(4'h4, 32'h0000_0005, "status_busy");
      end
    join
    repeat (3) @(posedge clock);
    #1;
    check("irq_after_stop", irq_o, 1);
    wb_read(4'h4, 32'h0000_0004, "status_idle");

    // Back-to-back frames: spacing 10*D+1 and level draining 2,1,0.
    wait_count(1, 1, "frame55_received");
    fall_cyc.delete();
    base_f = n_falls;
    base_fr = n_frames;
    send(8'hA5);
    send(8'h01);
    send(8'hFF);
    wb_read(4'h4, 32'h0000_0201, "level2");
    wait_count(base_f + 2, 0, "frame2_start");
    wb_read(4'h4, 32'h0000_0101, "level1");
    wait_count(base_f + 3, 0, "frame3_start");
    wb_read(4'h4, 32'h0000_0005, "level0");
    wait_count(base_fr + 3, 1, "three_frames_done");
    check("fall_count", fall_cyc.size(), 3);
    if (fall_cyc.size() >= 3) begin
      check("spacing_1_2", fall_cyc[1] - fall_cyc[0], 41);
      check("spacing_2_3", fall_cyc[2] - fall_cyc[1], 41);
    end
    check("tx_sb_drained", tx_sb.size(), 0);

    // FIFO fill and overflow at divisor 1000.
    wb_write(4'h8, 32'd1000, 4'b0011, "div1000");
    cur_div = 1000;
    send(8'h00);
    for (int i = 1; i <= 16; i++) send(8'(i));
    wb_read(4'h4, 32'h0000_1003, "full16");
    wb_write(4'h0, 32'h99, 4'b0001, "tx_overflow");
    wb_read(4'h4, 32'h0000_100B, "ovf_set");
    wb_write(4'h4, 32'h8, 4'b0001, "clr_ovf");
    wb_read(4'h4, 32'h0000_1003, "ovf_clr");
    wb_write(4'hC, 32'hFFFF_FFFF, 4'hF, "reserved_wr");
    wb_read(4'hC, 32'h0, "reserved_rd");

    // Divisor clamping and per-lane writes (current frame keeps its latched divisor).
    wb_write(4'h8, 32'd1, 4'b0011, "div_one");
    wb_read(4'h8, 32'd2, "div_clamped");
    wb_write(4'h8, 32'h1234, 4'b0001, "div_lane0");
    wb_read(4'h8, 32'h34, "div_lane0_rd");

    // Reset during DATA of the 0x00 frame: line must rise without a clock edge.
    begin : wait_data
      int t = 0;
      while (!(m_act && m_cnt >= 1200) && t < 3000) begin
        @(posedge clock); #1; t++;
      end
    end
    #3;
    check("tx_low_in_data", uart_tx, 0);
    reset = 1'b0;
    tx_sb.delete();
    cur_div = 86;
    #1;
    check("tx_async_rst", uart_tx, 1);
    check("irq_async_rst", irq_o, 1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    base_f = n_falls;
    wb_read(4'h4, 32'h0000_0004, "status_after_rst");
    wb_read(4'h8, 32'd86, "div_after_rst");
    repeat (300) @(posedge clock);
    #1;
    check("no_stale_frames", n_falls - base_f, 0);
    check("tx_idle_end", uart_tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
